// File: rtl/rom_arb_pkg.sv
// Shared constants, response payload type and round-robin helper for the ROM arbiter.
package rom_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT    = 4;
    localparam int unsigned ADDR_WIDTH_DEFAULT = 8;
    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam int unsigned ROM_DEPTH_DEFAULT  = 32;
    localparam int unsigned ID_WIDTH_DEFAULT   = $clog2(NUM_REQ_DEFAULT);
    localparam int unsigned RR_MAX_REQ         = 8;

    typedef struct packed {
        logic [ID_WIDTH_DEFAULT-1:0]   id;
        logic [DATA_WIDTH_DEFAULT-1:0] data;
        logic                          oor;
    } rsp_t;

    // First set bit of req searching last+1, last+2, ... modulo n; returns last if none set.
    function automatic logic [2:0] rr_next(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int unsigned n);
        logic [2:0] idx;
        logic [2:0] pick;
        pick = last;
        for (int unsigned k = RR_MAX_REQ; k >= 1; k--) begin
            idx = 3'((32'(last) + k) % n);
            if (k <= n && req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances on a completed transfer.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                advance,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] gnt_id
);
    import rom_arb_pkg::*;

    logic [ID_WIDTH-1:0] last_gnt;

    always_comb begin
        gnt    = '0;
        gnt_id = ID_WIDTH'(rr_next(8'(req), 3'(last_gnt), NUM_REQ));
        if (|req) gnt[gnt_id] = 1'b1;
    end

    // Reset pointer to the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt <= ID_WIDTH'(NUM_REQ - 1);
        end else if (advance) begin
            last_gnt <= gnt_id;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one combinational lookup ROM with a registered, ID-tagged response.
// Optional macro ROM_ARB_PIPE_EN inserts a registered ROM address stage (2-cycle latency).
module rom_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROM_DEPTH  = 32,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_oor,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    output logic                          rom_ce,
    output logic                          rom_ren,
    input  logic [DATA_WIDTH-1:0]         rom_data
);
    import rom_arb_pkg::*;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(ROM_DEPTH);

    logic [NUM_REQ-1:0]    gnt;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic                  accept;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_oor;
    logic                  rsp_load;
    logic [ID_WIDTH-1:0]   load_id;
    logic                  load_oor;
    logic [DATA_WIDTH-1:0] load_data;
    logic [0:0]            state_q;
    logic [0:0]            state_d;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req_valid),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_LIM);
    assign xfer      = accept & (|req_valid);
    assign req_ready = gnt & {NUM_REQ{accept}};
    assign rsp_valid = (state_q == S_FULL);

`ifdef ROM_ARB_PIPE_EN
    logic                  a_valid_q;
    logic [ADDR_WIDTH-1:0] a_addr_q;
    logic [ID_WIDTH-1:0]   a_id_q;
    logic                  a_oor_q;
    logic                  slot_free;
    logic                  a_adv;

    // Address stage advances whenever the response slot is free or draining.
    assign slot_free = !rsp_valid | rsp_ready;
    assign a_adv     = a_valid_q & slot_free;
    assign accept    = !a_valid_q | slot_free;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_valid_q <= 1'b0;
            a_addr_q  <= '0;
            a_id_q    <= '0;
            a_oor_q   <= 1'b0;
        end else begin
            if (xfer) begin
                a_valid_q <= 1'b1;
                a_addr_q  <= sel_addr;
                a_id_q    <= gnt_id;
                a_oor_q   <= sel_oor;
            end else if (a_adv) begin
                a_valid_q <= 1'b0;
            end
        end
    end

    assign rom_addr = a_addr_q;
    assign rom_ce   = a_valid_q;
    assign rom_ren  = a_valid_q;
    assign rsp_load = a_adv;
    assign load_id  = a_id_q;
    assign load_oor = a_oor_q;
`else
    logic [ADDR_WIDTH-1:0] rom_addr_q;

    assign accept = !rsp_valid | rsp_ready;

    // Address pins hold their last driven value between lookups.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rom_addr_q <= '0;
        end else if (xfer) begin
            rom_addr_q <= sel_addr;
        end
    end

    assign rom_addr = xfer ? sel_addr : rom_addr_q;
    assign rom_ce   = xfer;
    assign rom_ren  = xfer;
    assign rsp_load = xfer;
    assign load_id  = gnt_id;
    assign load_oor = sel_oor;
`endif

    // Out-of-range lookups never forward the ROM's undefined word.
    assign load_data = load_oor ? '0 : rom_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (rsp_load) state_d = S_FULL;
            S_FULL:  if (rsp_ready && !rsp_load) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_oor  <= 1'b0;
        end else if (rsp_load) begin
            rsp_id   <= load_id;
            rsp_data <= load_data;
            rsp_oor  <= load_oor;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: per-requester stimulus queues, expected-response queue, monitor.
module tb_rom_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 8;
`ifdef ROM_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic [NR-1:0]  req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]  req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [DW-1:0]  rsp_data;
    logic           rsp_oor;
    logic [AW-1:0]  rom_addr;
    logic           rom_ce;
    logic           rom_ren;
    logic [DW-1:0]  rom_data;

    rom_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROM_DEPTH  (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_oor   (rsp_oor),
        .rom_addr  (rom_addr),
        .rom_ce    (rom_ce),
        .rom_ren   (rom_ren),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;

    // ROM contents: 32 - addr for the 32 populated entries, junk elsewhere.
    always_comb rom_data = (rom_addr < 8'd32) ? 8'(32 - int'(rom_addr)) : 8'hEE;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       oor;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] aq[NR][32];
    int         head[NR];
    int         tail[NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic send(input int r, input int a);
        aq[r][tail[r]] = 8'(a);
        tail[r]++;
    endtask

    task automatic expect_rsp(input int id, input int data, input int oor);
        exp_t e;
        e.id   = 2'(id);
        e.data = 8'(data);
        e.oor  = 1'(oor);
        exp_q.push_back(e);
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) head[i] = tail[i];
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input int r);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
        end
        chk("grant_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        chk("rsp_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Requester driver: hold each address until its handshake completes.
    initial begin
        logic [NR-1:0] fire;
        req_valid = '0;
        req_addr  = '0;
        forever begin
            @(negedge clk);
            fire = resetn ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i]) head[i]++;
                req_valid[i] = (head[i] < tail[i]);
                req_addr[i*AW +: AW] = (head[i] < tail[i]) ? aq[i][head[i]] : 8'h00;
            end
        end
    end

    // Monitor: every consumed response must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id",   32'(rsp_id),   32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_oor",  32'(rsp_oor),  32'(e.oor));
                end
            end
        end
    end

    initial begin
        int run;
        resetn    = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id",    32'(rsp_id),    32'd0);
        chk("reset_rsp_data",  32'(rsp_data),  32'd0);
        chk("reset_rsp_oor",   32'(rsp_oor),   32'd0);
        chk("reset_rom_addr",  32'(rom_addr),  32'd0);
        chk("reset_rom_ce",    32'(rom_ce),    32'd0);
        chk("idle_req_ready",  32'(req_ready), 32'd0);
        resetn = 1'b1;

        // Single request: latency and ROM pin drive.
        @(negedge clk);
        send(0, 5);
        expect_rsp(0, 27, 0);
        wait_grant(0);
        repeat (LAT - 1) @(negedge clk);
        chk("rom_ce",   32'(rom_ce),   32'd1);
        chk("rom_ren",  32'(rom_ren),  32'd1);
        chk("rom_addr", 32'(rom_addr), 32'd5);
        @(negedge clk);
        chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_idle();

        // Fairness from reset: 0,1,2,3 twice.
        do_reset();
        @(negedge clk);
        for (int rd = 0; rd < 2; rd++) begin
            send(0, 0); send(1, 1); send(2, 2); send(3, 3);
            expect_rsp(0, 32, 0);
            expect_rsp(1, 31, 0);
            expect_rsp(2, 30, 0);
            expect_rsp(3, 29, 0);
        end
        wait_idle();

        // Range boundary.
        send(2, 40);
        expect_rsp(2, 0, 1);
        send(2, 31);
        expect_rsp(2, 1, 0);
        wait_idle();

        // Backpressure: pointer at 2, so requester 1 wins before requester 2.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        send(1, 7);
        send(2, 10);
        expect_rsp(1, 25, 0);
        expect_rsp(2, 22, 0);
        wait_rsp();
        for (int c = 0; c < 3; c++) begin
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_id",    32'(rsp_id),    32'd1);
            chk("stall_rsp_data",  32'(rsp_data),  32'd25);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle();

        // Reset while a response is held.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        send(0, 3);
        expect_rsp(0, 29, 0);
        wait_rsp();
        #2 resetn = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_rsp_data",  32'(rsp_data),  32'd0);
        flush();
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send(3, 12);
        send(0, 20);
        expect_rsp(0, 12, 0);
        expect_rsp(3, 20, 0);
        wait_idle();

        // Streaming: 16 back-to-back lookups, no bubbles.
        for (int a = 0; a < 16; a++) begin
            send(1, a);
            expect_rsp(1, 32 - a, 0);
        end
        wait_rsp();
        run = 1;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) run++;
        end
        chk("stream_run", 32'(run), 32'd16);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
